alu_issue_ctrl: RTL

Issue controller between decode and the shared ALU. Accepts one operation per cycle over a valid/ready handshake, applies per-opcode operand selection, and returns a registered result with flags. Single-cycle ops run back-to-back. DIV runs as a 32-iteration unsigned shift-subtract sequence, and `req_ready` stays low until it completes.

---
 rtl/alu_issue_ctrl_if.sv | 25 ++
 rtl/alu_issue_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Decode-to-ALU issue bundle: request handshake, operands, flush and registered response.
// master = decode side, slave = issue controller.
interface alu_issue_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  opcode;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] imm;
   logic        flush;
   logic        resp_valid;
   logic [31:0] result;
   logic [1:0]  flags;
   logic        busy;

   modport master (
      output req_valid, opcode, a, b, imm, flush,
      input  req_ready, resp_valid, result, flags, busy
   );

   modport slave (
      input  req_valid, opcode, a, b, imm, flush,
      output req_ready, resp_valid, result, flags, busy
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the shared ALU: single-cycle ops back-to-back, DIV as a
// multi-cycle restoring divider that holds off new requests until done.
module alu_issue_ctrl #(
   parameter int unsigned DIV_ITERS = 32
) (
   input  logic             clk,
   input  logic             rst,
   alu_issue_ctrl_if.slave  bus
);
   localparam int unsigned DW    = 32;
   localparam int unsigned CNT_W = $clog2(DIV_ITERS);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_ITERS - 2);
   localparam logic [CNT_W-1:0] DONE_CNT  = CNT_W'(DIV_ITERS - 1);

   localparam logic [4:0] OP_ADD   = 5'b00010;
   localparam logic [4:0] OP_ADDI  = 5'b00011;
   localparam logic [4:0] OP_SUB   = 5'b00100;
   localparam logic [4:0] OP_SUBI  = 5'b00101;
   localparam logic [4:0] OP_MUL   = 5'b00110;
   localparam logic [4:0] OP_MOVEH = 5'b00111;
   localparam logic [4:0] OP_DIV   = 5'b01000;
   localparam logic [4:0] OP_AND   = 5'b01010;
   localparam logic [4:0] OP_ANDI  = 5'b01011;
   localparam logic [4:0] OP_OR    = 5'b01100;
   localparam logic [4:0] OP_ORI   = 5'b01101;
   localparam logic [4:0] OP_NOT   = 5'b01110;
   localparam logic [4:0] OP_XOR   = 5'b10000;
   localparam logic [4:0] OP_XORI  = 5'b10001;
   localparam logic [4:0] OP_CMP   = 5'b10010;
   localparam logic [4:0] OP_ST    = 5'b11100;
   localparam logic [4:0] OP_LD    = 5'b11101;
   localparam logic [4:0] OP_MOVEL = 5'b11110;

   typedef enum logic {S_IDLE, S_DIV_RUN} state_e;

   state_e           state_q, state_d;
   logic [DW-1:0]    rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    result_q, result_d;
   logic [1:0]       flags_q, flags_d;
   logic             resp_q, resp_d;
   logic             busy_q;

   logic [DW-1:0]    x, y, alu_res;
   logic             accept;
   logic [DW-1:0]    st_r, st_q, st_d, step_r, step_q;
   logic [DW:0]      sh;
   logic             ge;

   assign accept = (state_q == S_IDLE) && bus.req_valid && !bus.flush;

   // Operand selection per opcode
   always_comb begin
      x = bus.a;
      y = bus.b;
      unique case (bus.opcode)
         OP_ST:                                       begin x = bus.b;   y = bus.imm;        end
         OP_LD, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI,
         OP_XORI:                                     begin x = bus.a;   y = bus.imm;        end
         OP_MOVEL:                                    begin x = bus.imm; y = 32'h0000_FFFF;  end
         OP_MOVEH:                                    begin x = bus.imm; y = 32'hFFFF_0000;  end
         default:                                     begin x = bus.a;   y = bus.b;          end
      endcase
   end

   always_comb begin
      alu_res = '0;
      unique case (bus.opcode)
         OP_ADD, OP_ADDI, OP_ST, OP_LD:        alu_res = x + y;
         OP_SUB, OP_SUBI, OP_CMP:              alu_res = x - y;
         OP_MUL:                               alu_res = x * y;
         OP_AND, OP_ANDI, OP_MOVEL, OP_MOVEH:  alu_res = x & y;
         OP_OR, OP_ORI:                        alu_res = x | y;
         OP_XOR, OP_XORI:                      alu_res = x ^ y;
         OP_NOT:                               alu_res = ~x;
         default:                              alu_res = '0;
      endcase
   end

   // One restoring-division step; the first step is folded into the DIV accept
   // so the quotient is ready one cycle before the controller returns to IDLE.
   assign st_r   = (state_q == S_IDLE) ? '0 : rem_q;
   assign st_q   = (state_q == S_IDLE) ? x  : quo_q;
   assign st_d   = (state_q == S_IDLE) ? y  : dvs_q;
   assign sh     = {st_r, st_q[DW-1]};
   assign ge     = sh >= {1'b0, st_d};
   assign step_r = ge ? DW'(sh - {1'b0, st_d}) : sh[DW-1:0];
   assign step_q = {st_q[DW-2:0], ge};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= 2'b01;
         resp_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         resp_q   <= resp_d;
         busy_q   <= (state_d == S_DIV_RUN);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (accept && bus.opcode == OP_DIV) state_d = S_DIV_RUN;
         S_DIV_RUN: if (bus.flush || cnt_q == DONE_CNT) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Datapath and response updates; flush suppresses both accept and DIV completion
   always_comb begin
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flags_d  = flags_q;
      resp_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (bus.opcode == OP_DIV) begin
                  rem_d = step_r;
                  quo_d = step_q;
                  dvs_d = y;
                  cnt_d = '0;
               end else begin
                  result_d = alu_res;
                  flags_d  = {alu_res[DW-1], alu_res == '0};
                  resp_d   = 1'b1;
               end
            end
         end
         S_DIV_RUN: begin
            if (!bus.flush && cnt_q != DONE_CNT) begin
               rem_d = step_r;
               quo_d = step_q;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_STEP) begin
                  result_d = step_q;
                  flags_d  = {step_q[DW-1], step_q == '0};
                  resp_d   = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.req_ready  = (state_q == S_IDLE) && !rst;
   assign bus.resp_valid = resp_q;
   assign bus.result     = result_q;
   assign bus.flags      = flags_q;
   assign bus.busy       = busy_q;
endmodule
